// File: rtl/alu_reservation_station.sv
// Reservation station and single-cycle integer ALU for the Tomasulo core. Holds issued
// ALU ops, wakes pending operands from the own and LSB result buses, and broadcasts one result per cycle.
module alu_reservation_station #(
  parameter int RS_SIZE  = 8,
  parameter int ROB_ADDR = 4
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                flush_in,
  input  logic                issue_valid,
  input  logic [3:0]          issue_op,
  input  logic [ROB_ADDR-1:0] issue_rob,
  input  logic [31:0]         issue_vj,
  input  logic [31:0]         issue_vk,
  input  logic                issue_qj_busy,
  input  logic                issue_qk_busy,
  input  logic [ROB_ADDR-1:0] issue_qj,
  input  logic [ROB_ADDR-1:0] issue_qk,
  input  logic                lsb_valid,
  input  logic [ROB_ADDR-1:0] lsb_rob,
  input  logic [31:0]         lsb_value,
  output logic                rs_full,
  output logic                out_valid,
  output logic [ROB_ADDR-1:0] out_rob,
  output logic [31:0]         out_value
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic                busy;
    logic [3:0]          op;
    logic [ROB_ADDR-1:0] rob;
    logic [31:0]         vj;
    logic [31:0]         vk;
    logic                qj_busy;
    logic                qk_busy;
    logic [ROB_ADDR-1:0] qj;
    logic [ROB_ADDR-1:0] qk;
  } entry_t;

  entry_t ent     [RS_SIZE];
  entry_t ent_nxt [RS_SIZE];

  logic [RS_SIZE-1:0] busy_vec;
  logic [RS_SIZE-1:0] ready_vec;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_found;
  logic [31:0]        alu_result;
  entry_t             iss_ent;

  // Both result buses are visible to every pending operand in the same cycle.
  function automatic logic bus_hit(input logic [ROB_ADDR-1:0] tag);
    return (out_valid && (out_rob == tag)) || (lsb_valid && (lsb_rob == tag));
  endfunction

  function automatic logic [31:0] bus_value(input logic [ROB_ADDR-1:0] tag);
    return (out_valid && (out_rob == tag)) ? out_value : lsb_value;
  endfunction

  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << sh;
      OP_SRL:  return a >> sh;
      OP_SRA:  return $unsigned($signed(a) >>> sh);
      OP_SLT:  return {31'b0, $signed(a) < $signed(b)};
      OP_SLTU: return {31'b0, a < b};
      default: return 32'd0;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_vec[i]  = ent[i].busy;
      ready_vec[i] = ent[i].busy && !ent[i].qj_busy && !ent[i].qk_busy;
    end
  end

  assign rs_full = &busy_vec;

  // Descending scan so the lowest index wins both searches.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    free_idx  = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_vec[i]) free_idx = IDX_W'(i);
      if (ready_vec[i]) begin
        sel_idx   = IDX_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  assign alu_result = alu(ent[sel_idx].op, ent[sel_idx].vj, ent[sel_idx].vk);

  // Incoming op, with pending operands forwarded if their producer broadcasts now.
  always_comb begin
    iss_ent         = '0;
    iss_ent.busy    = 1'b1;
    iss_ent.op      = issue_op;
    iss_ent.rob     = issue_rob;
    iss_ent.qj      = issue_qj;
    iss_ent.qk      = issue_qk;
    iss_ent.qj_busy = issue_qj_busy && !bus_hit(issue_qj);
    iss_ent.qk_busy = issue_qk_busy && !bus_hit(issue_qk);
    iss_ent.vj      = (issue_qj_busy && bus_hit(issue_qj)) ? bus_value(issue_qj) : issue_vj;
    iss_ent.vk      = (issue_qk_busy && bus_hit(issue_qk)) ? bus_value(issue_qk) : issue_vk;
  end

  // Next entry state for a normal cycle: wakeup, free the selected slot, then issue.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_nxt[i] = ent[i];
      if (ent[i].busy && ent[i].qj_busy && bus_hit(ent[i].qj)) begin
        ent_nxt[i].qj_busy = 1'b0;
        ent_nxt[i].vj      = bus_value(ent[i].qj);
      end
      if (ent[i].busy && ent[i].qk_busy && bus_hit(ent[i].qk)) begin
        ent_nxt[i].qk_busy = 1'b0;
        ent_nxt[i].vk      = bus_value(ent[i].qk);
      end
    end
    if (sel_found) ent_nxt[sel_idx].busy = 1'b0;
    // free_idx is never the selected slot: selection only picks busy entries.
    if (issue_valid && !rs_full) ent_nxt[free_idx] = iss_ent;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // values from before the edge regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      // NOTE: only the busy flags are reset; operand and tag payloads are don't-care
      // while an entry is free, so they are left unreset.
      for (int i = 0; i < RS_SIZE; i++) ent[i].busy <= 1'b0;
      out_valid <= 1'b0;
      out_rob   <= '0;
      out_value <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        for (int i = 0; i < RS_SIZE; i++) ent[i].busy <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        ent <= ent_nxt;
        out_valid <= sel_found;
        if (sel_found) begin
          out_rob   <= ent[sel_idx].rob;
          out_value <= alu_result;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench for alu_reservation_station: a slot-level reference model checked
// every cycle, plus directed vectors with hand-computed results.
module tb_alu_reservation_station;

  localparam int RS_SIZE  = 8;
  localparam int ROB_ADDR = 4;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4,
                         SLL = 4'd5, SRL = 4'd6, SRA = 4'd7, SLT = 4'd8, SLTU = 4'd9;

  logic                clk_in = 1'b0;
  logic                rst_in, rdy_in, flush_in;
  logic                issue_valid;
  logic [3:0]          issue_op;
  logic [ROB_ADDR-1:0] issue_rob, issue_qj, issue_qk;
  logic [31:0]         issue_vj, issue_vk;
  logic                issue_qj_busy, issue_qk_busy;
  logic                lsb_valid;
  logic [ROB_ADDR-1:0] lsb_rob;
  logic [31:0]         lsb_value;
  logic                rs_full, out_valid;
  logic [ROB_ADDR-1:0] out_rob;
  logic [31:0]         out_value;

  int checks = 0;
  int errors = 0;

  alu_reservation_station #(.RS_SIZE(RS_SIZE), .ROB_ADDR(ROB_ADDR)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_rob(issue_rob),
    .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj_busy(issue_qj_busy), .issue_qk_busy(issue_qk_busy),
    .issue_qj(issue_qj), .issue_qk(issue_qk),
    .lsb_valid(lsb_valid), .lsb_rob(lsb_rob), .lsb_value(lsb_value),
    .rs_full(rs_full), .out_valid(out_valid), .out_rob(out_rob), .out_value(out_value)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit         busy;
    logic [3:0] op;
    logic [3:0] rob;
    logic [31:0] vj, vk;
    bit         pj, pk;
    logic [3:0] qj, qk;
  } m_ent_t;

  m_ent_t      m [RS_SIZE];
  bit          model_on = 0;
  bit          m_ov;
  logic [3:0]  m_orob;
  logic [31:0] m_oval;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    logic [63:0] wide;
    sh = int'(b[4:0]);
    wide = {{32{a[31]}}, a};
    case (op)
      0: return a + b;
      1: return a + ~b + 32'd1;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a * (32'd1 << sh);
      6: return a / (32'd1 << sh);
      7: return wide[31 + sh -: 32];
      8: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      9: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Looks the tag up on the bus values present before the edge.
  function automatic bit on_bus(input logic [3:0] tag, output logic [31:0] val);
    val = '0;
    if (m_ov && m_orob == tag) begin val = m_oval; return 1; end
    if (lsb_valid && lsb_rob == tag) begin val = lsb_value; return 1; end
    return 0;
  endfunction

  task automatic model_step();
    m_ent_t      nx [RS_SIZE];
    int          sel, free;
    logic [31:0] v;
    bit          nov;
    logic [3:0]  nrob;
    logic [31:0] nval;
    if (rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) m[i].busy = 0;
      m_ov = 0; m_orob = 0; m_oval = 0; model_on = 1;
      return;
    end
    if (!rdy_in) return;
    if (flush_in) begin
      for (int i = 0; i < RS_SIZE; i++) m[i].busy = 0;
      m_ov = 0;
      return;
    end
    sel = -1; free = -1;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!m[i].busy && free < 0) free = i;
      if (m[i].busy && !m[i].pj && !m[i].pk && sel < 0) sel = i;
    end
    nx = m;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (m[i].busy && m[i].pj && on_bus(m[i].qj, v)) begin nx[i].pj = 0; nx[i].vj = v; end
      if (m[i].busy && m[i].pk && on_bus(m[i].qk, v)) begin nx[i].pk = 0; nx[i].vk = v; end
    end
    nov = 0; nrob = m_orob; nval = m_oval;
    if (sel >= 0) begin
      nx[sel].busy = 0;
      nov = 1; nrob = m[sel].rob; nval = ref_alu(m[sel].op, m[sel].vj, m[sel].vk);
    end
    if (issue_valid && free >= 0) begin
      nx[free].busy = 1; nx[free].op = issue_op; nx[free].rob = issue_rob;
      nx[free].qj = issue_qj; nx[free].qk = issue_qk;
      nx[free].vj = issue_vj; nx[free].vk = issue_vk;
      nx[free].pj = issue_qj_busy; nx[free].pk = issue_qk_busy;
      if (issue_qj_busy && on_bus(issue_qj, v)) begin nx[free].pj = 0; nx[free].vj = v; end
      if (issue_qk_busy && on_bus(issue_qk, v)) begin nx[free].pk = 0; nx[free].vk = v; end
    end
    m = nx;
    m_ov = nov; m_orob = nrob; m_oval = nval;
  endtask

  initial forever begin
    @(posedge clk_in);
    model_step();
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  initial forever begin
    @(negedge clk_in);
    if (model_on) begin
      bit full;
      full = 1;
      for (int i = 0; i < RS_SIZE; i++) if (!m[i].busy) full = 0;
      check("model_out_valid", out_valid, m_ov);
      check("model_rs_full", rs_full, full);
      check("model_out_rob", out_rob, m_orob);
      check("model_out_value", out_value, m_oval);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  task automatic do_issue(input logic [3:0] op, input logic [3:0] rob,
                          input logic [31:0] vj, input logic [31:0] vk,
                          input bit pj = 0, input logic [3:0] qj = 0,
                          input bit pk = 0, input logic [3:0] qk = 0);
    issue_valid = 1; issue_op = op; issue_rob = rob; issue_vj = vj; issue_vk = vk;
    issue_qj_busy = pj; issue_qj = qj; issue_qk_busy = pk; issue_qk = qk;
    @(negedge clk_in);
    issue_valid = 0; issue_qj_busy = 0; issue_qk_busy = 0;
  endtask

  task automatic lsb_set(input bit valid, input logic [3:0] rob, input logic [31:0] value);
    lsb_valid = valid; lsb_rob = rob; lsb_value = value;
  endtask

  task automatic expect_bcast(input string name, input logic [3:0] rob, input logic [31:0] value);
    check({name, "_valid"}, out_valid, 1);
    check({name, "_rob"}, out_rob, rob);
    check({name, "_value"}, out_value, value);
  endtask

  typedef struct { logic [3:0] op; logic [31:0] a, b, exp; } vec_t;
  vec_t vecs [10];

  initial begin
    vecs[0] = '{AND_,  32'h0000F0F0, 32'h00000FF0, 32'h000000F0};
    vecs[1] = '{OR_,   32'h000000F0, 32'h0000000F, 32'h000000FF};
    vecs[2] = '{XOR_,  32'h000000FF, 32'h0000000F, 32'h000000F0};
    vecs[3] = '{SLL,   32'h00000001, 32'h0000001F, 32'h80000000};
    vecs[4] = '{SRL,   32'h80000000, 32'h00000021, 32'h40000000};
    vecs[5] = '{SLT,   32'hFFFFFFFF, 32'h00000001, 32'h00000001};
    vecs[6] = '{SLT,   32'h00000001, 32'hFFFFFFFF, 32'h00000000};
    vecs[7] = '{ADD,   32'hFFFFFFFF, 32'h00000002, 32'h00000001};
    vecs[8] = '{4'd12, 32'h12345678, 32'h9ABCDEF0, 32'h00000000};
    vecs[9] = '{SRA,   32'h7FFFFFF0, 32'h00000004, 32'h07FFFFFF};

    rst_in = 1; rdy_in = 1; flush_in = 0;
    issue_valid = 0; issue_op = 0; issue_rob = 0; issue_vj = 0; issue_vk = 0;
    issue_qj_busy = 0; issue_qk_busy = 0; issue_qj = 0; issue_qk = 0;
    lsb_set(0, 0, 0);
    repeat (2) @(negedge clk_in);
    check("rst_out_valid", out_valid, 0);
    check("rst_rs_full", rs_full, 0);
    check("rst_out_rob", out_rob, 0);
    check("rst_out_value", out_value, 0);
    rst_in = 0;
    @(negedge clk_in);

    // Single ready ADD: one cycle to broadcast, valid for one cycle.
    do_issue(ADD, 3, 5, 7);
    check("add_not_yet", out_valid, 0);
    @(negedge clk_in);
    expect_bcast("add", 3, 12);
    @(negedge clk_in);
    check("add_one_cycle", out_valid, 0);

    // Back-to-back issues broadcast back-to-back in issue order.
    do_issue(SUB, 1, 0, 1);
    do_issue(SRA, 2, 32'h80000000, 4);
    expect_bcast("sub", 1, 32'hFFFFFFFF);
    do_issue(SLTU, 4, 1, 32'hFFFFFFFF);
    expect_bcast("sra", 2, 32'hF8000000);
    @(negedge clk_in);
    expect_bcast("sltu", 4, 1);

    foreach (vecs[k]) begin
      do_issue(vecs[k].op, 4'(8 + k % 8), vecs[k].a, vecs[k].b);
      @(negedge clk_in);
      expect_bcast($sformatf("vec%0d", k), 4'(8 + k % 8), vecs[k].exp);
    end
    @(negedge clk_in);
    check("idle", out_valid, 0);

    // Wakeup from the LSB bus.
    do_issue(ADD, 5, 0, 1, 1, 2);
    @(negedge clk_in);
    check("dep_waiting", out_valid, 0);
    lsb_set(1, 2, 100);
    @(negedge clk_in);
    lsb_set(0, 0, 0);
    check("dep_woken_not_sel", out_valid, 0);
    @(negedge clk_in);
    expect_bcast("dep", 5, 101);

    // Issue-time forwarding from the own result bus.
    do_issue(ADD, 6, 4, 5);
    check("prod_not_yet", out_valid, 0);
    @(negedge clk_in);
    expect_bcast("prod", 6, 9);
    do_issue(ADD, 7, 32'hDEADBEEF, 10, 1, 6);
    check("fwd_not_yet", out_valid, 0);
    @(negedge clk_in);
    expect_bcast("fwd", 7, 19);

    // Fill all slots with pending ops, then a ninth issue is ignored.
    for (int i = 0; i < RS_SIZE; i++) do_issue(ADD, 4'(i), 0, 32'(i), 1, 4'(8 + i));
    check("full_set", rs_full, 1);
    do_issue(ADD, 13, 1, 1);
    check("full_after_ninth", rs_full, 1);
    @(negedge clk_in);
    check("ninth_ignored", out_valid, 0);
    lsb_set(1, 11, 100);
    @(negedge clk_in);
    lsb_set(0, 0, 0);
    check("full_woken", rs_full, 1);
    check("woken_not_sel", out_valid, 0);
    // Issue while full in the cycle the woken slot is freed: must be dropped.
    issue_valid = 1; issue_op = ADD; issue_rob = 13; issue_vj = 1; issue_vk = 1;
    @(negedge clk_in);
    issue_valid = 0;
    expect_bcast("full_wake", 3, 103);
    check("full_dropped", rs_full, 0);
    lsb_set(1, 8, 7);
    @(negedge clk_in);
    lsb_set(0, 0, 0);
    check("freed_not_reused", out_valid, 0);
    @(negedge clk_in);
    expect_bcast("slot0", 0, 7);

    // rdy_in low: outputs and state frozen; bus activity and issues ignored.
    rdy_in = 0;
    lsb_set(1, 9, 1);
    issue_valid = 1; issue_op = ADD; issue_rob = 13; issue_vj = 1; issue_vk = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_in);
      expect_bcast($sformatf("frozen%0d", c), 0, 7);
    end
    rdy_in = 1; issue_valid = 0;
    lsb_set(0, 0, 0);
    @(negedge clk_in);
    check("resume_idle", out_valid, 0);
    @(negedge clk_in);
    check("resume_no_wake", out_valid, 0);

    // Flush drops every entry and a same-cycle issue.
    flush_in = 1;
    issue_valid = 1; issue_op = ADD; issue_rob = 13; issue_vj = 1; issue_vk = 1;
    @(negedge clk_in);
    flush_in = 0; issue_valid = 0;
    check("flush_valid", out_valid, 0);
    check("flush_full", rs_full, 0);
    foreach (vecs[k]) begin
      if (k < 6) begin
        lsb_set(1, 4'(9 + k + (k >= 2 ? 1 : 0)), 1);
        @(negedge clk_in);
        check($sformatf("flushed_quiet%0d", k), out_valid, 0);
      end
    end
    lsb_set(0, 0, 0);
    @(negedge clk_in);
    check("flushed_quiet_end", out_valid, 0);

    do_issue(ADD, 14, 2, 3);
    @(negedge clk_in);
    expect_bcast("post_flush", 14, 5);

    // Three pending entries flushed before their operand arrives.
    do_issue(XOR_, 1, 1, 0, 0, 0, 1, 2);
    do_issue(OR_,  2, 1, 0, 0, 0, 1, 2);
    do_issue(AND_, 3, 1, 0, 0, 0, 1, 2);
    check("three_not_full", rs_full, 0);
    flush_in = 1;
    @(negedge clk_in);
    flush_in = 0;
    lsb_set(1, 2, 32'h55);
    @(negedge clk_in);
    lsb_set(0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_in);
      check($sformatf("flush3_quiet%0d", c), out_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Reservation station plus single-cycle integer ALU for the Tomasulo core.
- Sits between dispatch and the ReorderBuffer, and is the producer end of the RoB's RS writeback port (`RS_RoBindex` / `RS_value`).
- Holds issued ALU ops and wakes operands from both result buses (own and LSB).
- Selects one ready entry per cycle, computes it and broadcasts the result tagged with its RoB index.

Parameters:
- RS_SIZE, 8, number of entries (power of two, 2..16).
- ROB_ADDR, 4, RoB index width.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  synchronous active-high reset.
- rdy_in  input  1  global enable; low = freeze all state.
- flush_in  input  1  mispredict flush.
- issue_valid  input  1  issue request this cycle.
- issue_op  input  4  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU; others give result 0.
- issue_rob  input  ROB_ADDR  destination RoB index.
- issue_vj, issue_vk  input  32  operand values (meaningful when not pending).
- issue_qj_busy, issue_qk_busy  input  1  operand still pending.
- issue_qj, issue_qk  input  ROB_ADDR  producer tag of pending operand.
- lsb_valid  input  1  LSB result broadcast valid.
- lsb_rob  input  ROB_ADDR  LSB result tag.
- lsb_value  input  32  LSB result.
- rs_full  output  1  all entries busy (combinational from state).
- out_valid  output  1  result broadcast valid (to RoB `RS_*` and to wakeup logic).
- out_rob  output  ROB_ADDR  result tag.
- out_value  output  32  result value.

Behaviour:
- Reset (rst_in=1 at a clock edge):
  - all entries not busy.
  - out_valid=0, out_rob=0, out_value=0.
  - rs_full=0.
- Priority per edge: rst_in, then rdy_in=0 (hold everything, outputs unchanged), then flush_in, then normal operation.
- flush_in=1 with rdy_in=1:
  - next cycle all entries free and out_valid=0.
  - a same-cycle issue is dropped.
- Issue:
  - issue_valid=1 and not rs_full: write into the lowest-index free entry.
  - issue_valid=1 with rs_full=1: ignored, no state change.
  - rs_full is evaluated on the current state; an entry freed this cycle is not reusable until next cycle.
- Issue-time forwarding: a pending operand whose tag matches a valid broadcast this cycle is captured as ready with that value.
  - Sources: out_valid/out_rob/out_value or lsb_valid/lsb_rob/lsb_value.
  - If both buses match, either value is acceptable (tags unique).
- Wakeup: every busy entry with a pending operand compares its tag against both buses each cycle; on match, latch the value and clear pending.
- Select:
  - the lowest-index busy entry with both operands ready (state at start of cycle) is executed.
  - at the edge: out_valid=1, out_rob=entry tag, out_value=ALU result, and the entry is freed.
  - no ready entry: out_valid=0, out_rob/out_value hold.
  - an entry woken this cycle is eligible next cycle.
- Latency: issue with both operands ready at edge N, selected during cycle N+1, broadcast visible after edge N+1 (one cycle valid).
- Dependent chain: result broadcast cycle M, dependent woken at edge M, its own broadcast after edge M+1.
- ALU arithmetic: 32-bit, wrap-around on ADD/SUB.
  - Shifts use vk[4:0].
  - SRA is arithmetic.
  - SLT signed, SLTU unsigned; result 1 or 0.
- Simultaneous issue + select + wakeup in one cycle is legal.
  - Issue targets a free entry only, never the entry being freed.

Test Plan:
- Reset -> out_valid=0, rs_full=0. Issue ADD vj=5 vk=7 rob=3 -> exactly one cycle later out_valid=1, rob=3, value=12, then out_valid=0.
- Issue SUB vj=0 vk=1 rob=1 then SRA vj=0x80000000 vk=4 rob=2 then SLTU vj=1 vk=0xFFFFFFFF rob=4 -> values 0xFFFFFFFF, 0xF8000000, 1, in rob order 1,2,4.
- Issue ADD rob=5 with qj pending tag 2; later lsb_valid rob=2 value=100, vk=1 -> broadcast rob=5 value=101 two edges after the LSB pulse edge.
- Issue with qj=6 pending in the same cycle as out_valid rob=6 value=9 -> forwarded, result produced without further wakeup.
- Issue 8 entries all pending -> rs_full=1; ninth issue ignored; wake one via LSB -> broadcast, then rs_full drops.
- Fill 3 entries, assert flush_in -> next cycle out_valid=0, no broadcast ever for those tags. rdy_in low for 5 cycles mid-run -> state and outputs frozen, then resume identically.
